pipe_perf_monitor: RTL and testbench
====================================

// Module: pipe_perf_monitor
// PURPOSE
//   Synthesizable run monitor for the pipelined CPU. Replaces bench-side stall/flush/PC printing with on-chip logic.
//   Counts run cycles and NUM_EVT per-cycle hazard events (stall, flush, ...) over a bounded run window.
//   Exposes all counters through a registered read port; optionally buffers per-cycle PC samples in a trace FIFO.
//   Sits beside the CPU top and taps the HDU, control and PC signals.
// PARAMETERS
//   NUM_EVT      4    number of event inputs / event counters (1..15)
//   CNT_W        32   width of every counter, cycle counter included
//   PC_W         32   width of pc_i and of trace entries
//   CYCLE_LIMIT  30   run length in cycles; 0 = unlimited (stop_i only)
//   TRACE_DEPTH  16   trace FIFO entries, power of 2 (used only with PPM_TRACE_FIFO_EN)
// PORTS
//   clk           in   1        clock, all state updates on posedge
//   rst           in   1        asynchronous active-high reset
//   start_i       in   1        begin run (accepted in IDLE or DONE)
//   stop_i        in   1        end run early (accepted in RUN)
//   clr_i         in   1        synchronous clear of counters/flags, returns to IDLE
//   evt_i         in   NUM_EVT  per-cycle event strobes, bit k -> counter k
//   pc_i          in   PC_W     current PC, trace sample source
//   rd_sel_i      in   4        0 = cycle count, k+1 = event counter k
//   rd_data_o     out  CNT_W    registered read data
//   running_o     out  1        1 while in RUN
//   done_o        out  1        1 while in DONE
//   trace_valid_o out  1        FIFO non-empty
//   trace_ready_i in   1        consumer pops when valid & ready
//   trace_pc_o    out  PC_W     FIFO head (valid only with trace_valid_o)
//   trace_ovf_o   out  1        sticky: a sample was dropped on full
// BEHAVIOUR
//   Reset: state IDLE; all counters 0; rd_data_o, running_o, done_o, trace_valid_o, trace_ovf_o = 0; FIFO empty.
//   FSM: IDLE, RUN, DONE. Priority in every state: clr_i > start_i > stop_i/limit.
//     IDLE: start_i -> RUN; cycle counter and all event counters cleared on that edge.
//     RUN: each cycle cycle_cnt += 1, and cnt[k] += 1 for every set evt_i[k].
//       The stop cycle's events are counted (stop_i, or increment making cycle_cnt == CYCLE_LIMIT) -> DONE.
//     DONE: counters frozen; start_i -> RUN with clear (restart); stop_i ignored.
//     clr_i in any state: counters 0, trace_ovf_o 0, FIFO emptied, state IDLE; overrides same-cycle start_i.
//   Counters saturate at all-ones; they never wrap.
//   evt_i is sampled only in RUN; ignored in IDLE/DONE.
//   Read: rd_data_o updates 1 cycle after rd_sel_i. It shows the counter value after that edge's update.
//     Unmapped rd_sel_i (> NUM_EVT) returns 0.
//   running_o/done_o are registered decodes of state; they change on the edge the state changes.
//   Reset asserted mid-run forces IDLE immediately; no partial results survive.
// CONFIGURATION
//   PPM_TRACE_FIFO_EN defined:
//     Each RUN cycle pushes pc_i into a TRACE_DEPTH FIFO.
//     Pop occurs on trace_valid_o & trace_ready_i; trace_pc_o is the head, first-word fall-through.
//     Full and no pop: sample dropped, trace_ovf_o set (sticky until clr_i/rst).
//     Full with same-cycle pop: push accepted, no overflow.
//     Pops remain allowed in IDLE/DONE to drain the FIFO.
//   PPM_TRACE_FIFO_EN undefined:
//     No FIFO storage. trace_valid_o, trace_pc_o, trace_ovf_o tied 0; trace_ready_i ignored.
// TESTING
//   1. rst then start_i 1 cycle, evt_i=0, no stop -> running_o 30 cycles, done_o; rd_sel 0 reads 30.
//   2. RUN with evt_i[0] on cycles 3,4,5 and evt_i[1] on cycle 7 -> at DONE, sel1 = 3 and sel2 = 1.
//   3. stop_i at RUN cycle 10 with evt_i[0]=1 that cycle -> DONE, cycle = 10, event counted.
//   4. CNT_W=4, CYCLE_LIMIT=0, evt_i[0] held 20 cycles -> sel1 saturates at 15; cycle holds 15.
//   5. start_i and clr_i same cycle in DONE -> IDLE, counters 0; rst pulse mid-RUN -> all outputs 0 async.
//   6. PPM_TRACE_FIFO_EN, depth 16, ready=0 for 20 RUN cycles -> 16 PCs kept, trace_ovf_o=1.
//      Then ready=1 -> PCs drain in order.

Source files
------------

// File: rtl/pipe_perf_monitor.sv
// pipe_perf_monitor: run-window monitor for the pipelined CPU.
// Counts run cycles and NUM_EVT per-cycle hazard events over a bounded run window.
// All counters are exposed through a registered read port selected by rd_sel_i.
// Optional PC trace FIFO is built only when the macro PPM_TRACE_FIFO_EN is defined.
// Without it, the trace outputs are tied to 0.
module pipe_perf_monitor #(
    parameter int NUM_EVT     = 4,
    parameter int CNT_W       = 32,
    parameter int PC_W        = 32,
    parameter int CYCLE_LIMIT = 30,
    parameter int TRACE_DEPTH = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start_i,
    input  logic               stop_i,
    input  logic               clr_i,
    input  logic [NUM_EVT-1:0] evt_i,
    input  logic [PC_W-1:0]    pc_i,
    input  logic [3:0]         rd_sel_i,
    output logic [CNT_W-1:0]   rd_data_o,
    output logic               running_o,
    output logic               done_o,
    output logic               trace_valid_o,
    input  logic               trace_ready_i,
    output logic [PC_W-1:0]    trace_pc_o,
    output logic               trace_ovf_o
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } state_e;

    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(CYCLE_LIMIT);

    state_e                        state_q, state_d;
    logic [CNT_W-1:0]              cycle_cnt_q, cycle_cnt_d;
    logic [NUM_EVT-1:0][CNT_W-1:0] evt_cnt_q, evt_cnt_d;
    logic [CNT_W-1:0]              rd_data_q, rd_data_d;
    logic                          running_q, done_q;
    logic                          clr_cnt;    // zero all counters on this edge
    logic                          cnt_en;     // this edge is a RUN cycle
    logic                          limit_hit;  // this RUN cycle reaches CYCLE_LIMIT

    // Counters stick at all-ones rather than wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    assign limit_hit = (CYCLE_LIMIT != 0) && (sat_inc(cycle_cnt_q) == LIMIT);

    // Next-state decode; clr_i beats start_i, which beats stop_i and the limit.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        state_d = state_q;
        clr_cnt = 1'b0;
        cnt_en  = 1'b0;
        if (clr_i) begin
            state_d = ST_IDLE;
            clr_cnt = 1'b1;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (start_i) begin
                        state_d = ST_RUN;
                        clr_cnt = 1'b1;
                    end
                end
                ST_RUN: begin
                    cnt_en = 1'b1;
                    if (stop_i || limit_hit) state_d = ST_DONE;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Counter next values: clear on start/clr, count during RUN, freeze otherwise.
    always_comb begin
        cycle_cnt_d = cycle_cnt_q;
        evt_cnt_d   = evt_cnt_q;
        if (clr_cnt) begin
            cycle_cnt_d = '0;
            evt_cnt_d   = '0;
        end else if (cnt_en) begin
            cycle_cnt_d = sat_inc(cycle_cnt_q);
            for (int k = 0; k < NUM_EVT; k++) begin
                if (evt_i[k]) evt_cnt_d[k] = sat_inc(evt_cnt_q[k]);
            end
        end
    end

    // Read mux looks at post-update counter values; unmapped selects read 0.
    always_comb begin
        rd_data_d = '0;
        if (rd_sel_i == 4'd0) rd_data_d = cycle_cnt_d;
        for (int k = 0; k < NUM_EVT; k++) begin
            if (rd_sel_i == 4'(k + 1)) rd_data_d = evt_cnt_d[k];
        end
    end

    // State, counters, read data and status flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cycle_cnt_q <= '0;
            evt_cnt_q   <= '0;
            rd_data_q   <= '0;
            running_q   <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state_q     <= state_d;
            cycle_cnt_q <= cycle_cnt_d;
            evt_cnt_q   <= evt_cnt_d;
            rd_data_q   <= rd_data_d;
            running_q   <= (state_d == ST_RUN);
            done_q      <= (state_d == ST_DONE);
        end
    end

    assign rd_data_o = rd_data_q;
    assign running_o = running_q;
    assign done_o    = done_q;

`ifdef PPM_TRACE_FIFO_EN
    localparam int          AW      = $clog2(TRACE_DEPTH);
    localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

    logic [PC_W-1:0] fifo_mem [TRACE_DEPTH];
    logic [AW:0]     wr_ptr_q, wr_ptr_d;
    logic [AW:0]     rd_ptr_q, rd_ptr_d;
    logic            ovf_q, ovf_d;
    logic            fifo_empty, fifo_full;
    logic            do_pop, push_req, do_push;

    // Pointers carry one extra wrap bit to tell full from empty.
    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                        (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign do_pop     = !fifo_empty && trace_ready_i;
    assign push_req   = (state_q == ST_RUN) && !clr_i;
    // A pop on the same edge frees the slot, so a full FIFO can still accept.
    assign do_push    = push_req && (!fifo_full || do_pop);

    // FIFO pointer and sticky overflow next values.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        ovf_d    = ovf_q;
        if (clr_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            ovf_d    = 1'b0;
        end else begin
            if (do_pop)              rd_ptr_d = rd_ptr_q + PTR_ONE;
            if (do_push)             wr_ptr_d = wr_ptr_q + PTR_ONE;
            if (push_req && !do_push) ovf_d   = 1'b1;
        end
    end

    // FIFO control registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            ovf_q    <= ovf_d;
        end
    end

    // Sample storage.
    // NOTE: storage is not reset; its contents are only ever qualified by trace_valid_o.
    always_ff @(posedge clk) begin
        if (do_push) fifo_mem[wr_ptr_q[AW-1:0]] <= pc_i;
    end

    assign trace_valid_o = !fifo_empty;
    assign trace_pc_o    = fifo_mem[rd_ptr_q[AW-1:0]];
    assign trace_ovf_o   = ovf_q;
`else
    logic unused_trace;

    assign unused_trace  = ^{trace_ready_i, pc_i};
    assign trace_valid_o = 1'b0;
    assign trace_pc_o    = '0;
    assign trace_ovf_o   = 1'b0;
`endif

endmodule

// File: tb/tb_pipe_perf_monitor.sv
// Testbench for pipe_perf_monitor: directed scenarios plus a random phase.
// Two DUTs share the stimulus: a default build (32-bit counters, 30-cycle limit)
// and a narrow build (4-bit counters, unlimited) that exercises saturation.
// A reference model predicts every post-edge output into a scoreboard queue.
// A negedge monitor pops that queue and also checks trace PCs as they are consumed.
module tb_pipe_perf_monitor;

    localparam int NE    = 4;
    localparam int DEPTH = 16;
`ifdef PPM_TRACE_FIFO_EN
    localparam bit TRACE_EN = 1'b1;
`else
    localparam bit TRACE_EN = 1'b0;
`endif
    localparam int M_IDLE = 0;
    localparam int M_RUN  = 1;
    localparam int M_DONE = 2;

    typedef struct packed {
        logic [31:0] rd_a;
        logic [3:0]  rd_b;
        logic        run_a;
        logic        done_a;
        logic        run_b;
        logic        done_b;
        logic        tv_a;
        logic        ovf_a;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0, stop = 1'b0, clr = 1'b0, ready = 1'b0;
    logic [NE-1:0] evt = '0;
    logic [31:0]   pc = '0;
    logic [3:0]    sel = '0;

    logic [31:0] rd_a;
    logic        run_a, done_a, tv_a, ovf_a;
    logic [31:0] tpc_a;
    logic [3:0]  rd_b;
    logic        run_b, done_b, tv_b, ovf_b;
    logic [31:0] tpc_b;
    logic        unused_b;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    int          m_mode [2];
    longint      m_cyc  [2];
    longint      m_ev   [2][NE];
    longint      m_max  [2];
    longint      m_lim  [2];
    int          occ;
    bit          m_ovf;
    exp_t        exp_q[$];
    logic [31:0] pc_exp_q[$];

    always #5 clk = ~clk;

    pipe_perf_monitor #(.NUM_EVT(NE), .CNT_W(32), .PC_W(32), .CYCLE_LIMIT(30), .TRACE_DEPTH(DEPTH)) dut_a (
        .clk(clk), .rst(rst), .start_i(start), .stop_i(stop), .clr_i(clr), .evt_i(evt),
        .pc_i(pc), .rd_sel_i(sel), .rd_data_o(rd_a), .running_o(run_a), .done_o(done_a),
        .trace_valid_o(tv_a), .trace_ready_i(ready), .trace_pc_o(tpc_a), .trace_ovf_o(ovf_a)
    );

    pipe_perf_monitor #(.NUM_EVT(NE), .CNT_W(4), .PC_W(32), .CYCLE_LIMIT(0), .TRACE_DEPTH(DEPTH)) dut_b (
        .clk(clk), .rst(rst), .start_i(start), .stop_i(stop), .clr_i(clr), .evt_i(evt),
        .pc_i(pc), .rd_sel_i(sel), .rd_data_o(rd_b), .running_o(run_b), .done_o(done_b),
        .trace_valid_o(tv_b), .trace_ready_i(ready), .trace_pc_o(tpc_b), .trace_ovf_o(ovf_b)
    );

    assign unused_b = ^{tv_b, tpc_b, ovf_b};

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic longint sat(input longint v, input longint mx);
        return (v > mx) ? mx : v;
    endfunction

    function automatic longint rd_val(input int i, input logic [3:0] s);
        if (s == 4'd0) return m_cyc[i];
        if (int'(s) <= NE) return m_ev[i][int'(s) - 1];
        return 0;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_mode[i] = M_IDLE;
            m_cyc[i]  = 0;
            for (int k = 0; k < NE; k++) m_ev[i][k] = 0;
        end
        occ   = 0;
        m_ovf = 1'b0;
        pc_exp_q.delete();
        exp_q.delete();
    endtask

    // Advance the model by one clock edge using the inputs currently applied.
    task automatic model_step();
        exp_t e;
        bit   pop;
        pop = TRACE_EN && (occ > 0) && ready;
        if (clr) begin
            occ   = 0;
            m_ovf = 1'b0;
            pc_exp_q.delete();
        end else begin
            if (pop) occ--;
            if (TRACE_EN && m_mode[0] == M_RUN) begin
                if (occ < DEPTH) begin
                    occ++;
                    pc_exp_q.push_back(pc);
                end else begin
                    m_ovf = 1'b1;
                end
            end
        end
        for (int i = 0; i < 2; i++) begin
            if (clr || (start && m_mode[i] != M_RUN)) begin
                m_mode[i] = clr ? M_IDLE : M_RUN;
                m_cyc[i]  = 0;
                for (int k = 0; k < NE; k++) m_ev[i][k] = 0;
            end else if (m_mode[i] == M_RUN) begin
                m_cyc[i] = sat(m_cyc[i] + 1, m_max[i]);
                for (int k = 0; k < NE; k++)
                    if (evt[k]) m_ev[i][k] = sat(m_ev[i][k] + 1, m_max[i]);
                if (stop || (m_lim[i] != 0 && m_cyc[i] == m_lim[i])) m_mode[i] = M_DONE;
            end
        end
        e.rd_a   = 32'(rd_val(0, sel));
        e.rd_b   = 4'(rd_val(1, sel));
        e.run_a  = (m_mode[0] == M_RUN);
        e.done_a = (m_mode[0] == M_DONE);
        e.run_b  = (m_mode[1] == M_RUN);
        e.done_b = (m_mode[1] == M_DONE);
        e.tv_a   = (occ > 0);
        e.ovf_a  = m_ovf;
        exp_q.push_back(e);
    endtask

    // Apply one cycle of inputs; returns 1 time unit after the edge.
    task automatic cyc(input bit s, input bit st, input bit c, input logic [NE-1:0] e,
                       input logic [3:0] rs, input bit rdy);
        start = s;
        stop  = st;
        clr   = c;
        evt   = e;
        sel   = rs;
        ready = rdy;
        pc    = $urandom;
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_rd_a"}, 64'(rd_a), 64'd0);
        check({tag, "_rd_b"}, 64'(rd_b), 64'd0);
        check({tag, "_run"},  64'(run_a), 64'd0);
        check({tag, "_done"}, 64'(done_a), 64'd0);
        check({tag, "_tv"},   64'(tv_a), 64'd0);
        check({tag, "_ovf"},  64'(ovf_a), 64'd0);
    endtask

    // Scoreboard monitor: compare every predicted cycle and every consumed trace entry.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("rd_a",   64'(rd_a),   64'(e.rd_a));
            check("rd_b",   64'(rd_b),   64'(e.rd_b));
            check("run_a",  64'(run_a),  64'(e.run_a));
            check("done_a", 64'(done_a), 64'(e.done_a));
            check("run_b",  64'(run_b),  64'(e.run_b));
            check("done_b", 64'(done_b), 64'(e.done_b));
            check("tvalid", 64'(tv_a),   64'(e.tv_a));
            check("tovf",   64'(ovf_a),  64'(e.ovf_a));
        end
        if (!rst && tv_a === 1'b1 && ready === 1'b1) begin
            if (pc_exp_q.size() == 0) check("trace_unexpected_pop", 64'(tv_a), 64'd0);
            else                      check("trace_pc", 64'(tpc_a), 64'(pc_exp_q.pop_front()));
        end
    end

    initial begin
        m_max[0] = 64'hFFFF_FFFF;
        m_max[1] = 15;
        m_lim[0] = 30;
        m_lim[1] = 0;
        model_reset();

        // Power-on reset
        #1 rst = 1'b1;
        #3 check_all_zero("reset");
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;

        // Test 1: free run to the 30-cycle limit
        cyc(1, 0, 0, '0, 4'd0, 1);
        for (int n = 1; n <= 32; n++) cyc(0, 0, 0, '0, 4'd0, 1);
        check("t1_cycles", 64'(rd_a), 64'd30);
        check("t1_done", 64'(done_a), 64'd1);

        // Test 2: evt0 on RUN cycles 3..5, evt1 on cycle 7
        cyc(1, 0, 0, '0, 4'd0, 1);
        for (int n = 1; n <= 32; n++) begin
            logic [NE-1:0] e;
            e = '0;
            e[0] = (n >= 3 && n <= 5);
            e[1] = (n == 7);
            cyc(0, 0, 0, e, 4'd0, 1);
        end
        cyc(0, 0, 0, '0, 4'd1, 1);
        check("t2_evt0", 64'(rd_a), 64'd3);
        cyc(0, 0, 0, '0, 4'd2, 1);
        check("t2_evt1", 64'(rd_a), 64'd1);

        // Test 3: stop at RUN cycle 10 with evt0 in that cycle
        cyc(1, 0, 0, '0, 4'd0, 1);
        for (int n = 1; n <= 10; n++) cyc(0, n == 10, 0, (n == 10) ? 4'b0001 : 4'b0000, 4'd0, 1);
        check("t3_cycles", 64'(rd_a), 64'd10);
        check("t3_done", 64'(done_a), 64'd1);
        cyc(0, 0, 0, '1, 4'd1, 1);
        check("t3_evt0", 64'(rd_a), 64'd1);

        // Test 4: 4-bit counters saturate
        cyc(1, 0, 0, '0, 4'd1, 1);
        for (int n = 1; n <= 20; n++) cyc(0, 0, 0, 4'b0001, 4'd1, 1);
        check("t4_sat_evt", 64'(rd_b), 64'd15);
        cyc(0, 1, 0, 4'b0001, 4'd0, 1);
        check("t4_sat_cyc", 64'(rd_b), 64'd15);
        check("t4_b_done", 64'(done_b), 64'd1);

        // Test 5: clr beats start in DONE, then async reset mid-run
        cyc(1, 0, 1, '0, 4'd0, 1);
        check("t5_clr_rd", 64'(rd_a), 64'd0);
        check("t5_clr_run", 64'(run_a), 64'd0);
        check("t5_clr_done", 64'(done_a), 64'd0);
        cyc(1, 0, 0, '0, 4'd0, 0);
        for (int n = 1; n <= 6; n++) cyc(0, 0, 0, 4'b0011, 4'd1, 0);
        #2 rst = 1'b1;
        #1 check_all_zero("t5_async");
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;

        // Test 6: trace fills with ready low, overflows, then drains in order
        cyc(1, 0, 0, '0, 4'd0, 0);
        for (int n = 1; n <= 20; n++) cyc(0, n == 20, 0, '0, 4'd0, 0);
        check("t6_ovf", 64'(ovf_a), 64'(TRACE_EN));
        check("t6_valid", 64'(tv_a), 64'(TRACE_EN));
        for (int n = 0; n < 20; n++) cyc(0, 0, 0, '0, 4'd0, 1);
        check("t6_drained", 64'(tv_a), 64'd0);

        // Random phase
        for (int n = 0; n < 1500; n++) begin
            cyc($urandom_range(0, 99) < 4, $urandom_range(0, 99) < 3, $urandom_range(0, 99) < 1,
                NE'($urandom), 4'($urandom_range(0, 15)), $urandom_range(0, 1) == 1);
        end

        cyc(0, 0, 0, '0, 4'd0, 1);
        @(negedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
